// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: steps through the instruction ROM, resolves
// branches and halts from the decoder, and counts retired instructions and taken branches.
module fetch_unit #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             BranchEn,
    input  logic             ConditionBranch,
    input  logic             CondFlag,
    input  logic [PC_W-1:0]  BranchTarget,
    input  logic             Halt,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Fetching,
    output logic             Done,
    output logic [CNT_W-1:0] InstCount,
    output logic [CNT_W-1:0] BranchCount
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    state_t state;

    logic             take_branch;
    logic [PC_W-1:0]  pc_next_seq;
    logic [CNT_W-1:0] inst_inc;
    logic [CNT_W-1:0] branch_inc;

    always_comb begin
        take_branch = BranchEn && (!ConditionBranch || CondFlag);
        // Sequential PC wraps naturally at the address-width boundary.
        pc_next_seq = ProgCtr + PC_W'(1);
        inst_inc    = (InstCount == {CNT_W{1'b1}}) ? InstCount : InstCount + CNT_W'(1);
        branch_inc  = (BranchCount == {CNT_W{1'b1}}) ? BranchCount : BranchCount + CNT_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= StIdle;
            ProgCtr     <= '0;
            Fetching    <= 1'b0;
            Done        <= 1'b0;
            InstCount   <= '0;
            BranchCount <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (Start) begin
                        state       <= StRun;
                        ProgCtr     <= StartAddr;
                        Fetching    <= 1'b1;
                        Done        <= 1'b0;
                        InstCount   <= '0;
                        BranchCount <= '0;
                    end
                end
                StRun: begin
                    InstCount <= inst_inc;
                    if (Halt) begin
                        // PC stays on the halt instruction for post-run inspection.
                        state    <= StDone;
                        Fetching <= 1'b0;
                        Done     <= 1'b1;
                    end else if (take_branch) begin
                        ProgCtr     <= BranchTarget;
                        BranchCount <= branch_inc;
                    end else begin
                        ProgCtr <= pc_next_seq;
                    end
                end
                default: begin
                    state    <= StIdle;
                    Fetching <= 1'b0;
                    Done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Drives two fetch_unit instances (16-bit and 4-bit counters) with identical stimulus
// and compares both against a spec-level reference model.
module tb_fetch_unit;

    localparam int unsigned PC_W = 10;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Start;
    logic [PC_W-1:0] StartAddr;
    logic            BranchEn;
    logic            ConditionBranch;
    logic            CondFlag;
    logic [PC_W-1:0] BranchTarget;
    logic            Halt;

    logic [PC_W-1:0] pc_a, pc_b;
    logic            fetching_a, fetching_b, done_a, done_b;
    logic [15:0]     inst_a, branch_a;
    logic [3:0]      inst_b, branch_b;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 running, 2 done; counts are unbounded.
    int m_state = 0;
    int m_pc    = 0;
    int m_inst  = 0;
    int m_br    = 0;

    always #5 Clk = ~Clk;

    fetch_unit #(.PC_W(PC_W), .CNT_W(16)) dut_a (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .BranchEn(BranchEn), .ConditionBranch(ConditionBranch), .CondFlag(CondFlag),
        .BranchTarget(BranchTarget), .Halt(Halt), .ProgCtr(pc_a), .Fetching(fetching_a),
        .Done(done_a), .InstCount(inst_a), .BranchCount(branch_a)
    );

    fetch_unit #(.PC_W(PC_W), .CNT_W(4)) dut_b (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .BranchEn(BranchEn), .ConditionBranch(ConditionBranch), .CondFlag(CondFlag),
        .BranchTarget(BranchTarget), .Halt(Halt), .ProgCtr(pc_b), .Fetching(fetching_b),
        .Done(done_b), .InstCount(inst_b), .BranchCount(branch_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic idle_inputs();
        Reset = 1'b0; Start = 1'b0; StartAddr = '0; BranchEn = 1'b0;
        ConditionBranch = 1'b0; CondFlag = 1'b0; BranchTarget = '0; Halt = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        @(posedge Clk);
        if (Reset) begin
            m_state = 0; m_pc = 0; m_inst = 0; m_br = 0;
        end else if (m_state == 1) begin
            m_inst++;
            if (Halt) begin
                m_state = 2;
            end else if (BranchEn && (!ConditionBranch || CondFlag)) begin
                m_pc = int'(BranchTarget);
                m_br++;
            end else begin
                m_pc = (m_pc + 1) % (1 << PC_W);
            end
        end else if (Start) begin
            m_state = 1; m_pc = int'(StartAddr); m_inst = 0; m_br = 0;
        end
        #1;
        check("pc_a", 32'(pc_a), 32'(m_pc));
        check("pc_b", 32'(pc_b), 32'(m_pc));
        check("fetching_a", 32'(fetching_a), 32'(m_state == 1));
        check("fetching_b", 32'(fetching_b), 32'(m_state == 1));
        check("done_a", 32'(done_a), 32'(m_state == 2));
        check("done_b", 32'(done_b), 32'(m_state == 2));
        check("inst_a", 32'(inst_a), 32'(sat(m_inst, 65535)));
        check("inst_b", 32'(inst_b), 32'(sat(m_inst, 15)));
        check("branch_a", 32'(branch_a), 32'(sat(m_br, 65535)));
        check("branch_b", 32'(branch_b), 32'(sat(m_br, 15)));
    endtask

    task automatic start_at(input logic [PC_W-1:0] addr);
        Start = 1'b1; StartAddr = addr;
        step();
        Start = 1'b0;
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();

        // Start and sequential fetch
        start_at(10'h005);
        check("first_pc", 32'(pc_a), 32'h005);
        repeat (3) step();
        check("seq_pc", 32'(pc_a), 32'h008);
        check("seq_inst", 32'(inst_a), 32'd3);

        // Unconditional jump to 0x010, then conditional not-taken / taken
        BranchEn = 1'b1; BranchTarget = 10'h010;
        step();
        ConditionBranch = 1'b1; CondFlag = 1'b0; BranchTarget = 10'h3A0;
        step();
        check("cond_nt_pc", 32'(pc_a), 32'h011);
        CondFlag = 1'b1; BranchTarget = 10'h040;
        step();
        check("cond_t_pc", 32'(pc_a), 32'h040);
        check("cond_t_br", 32'(branch_a), 32'd2);

        // Jump to 0x020 then halt with branch asserted
        ConditionBranch = 1'b0; BranchTarget = 10'h020;
        step();
        Halt = 1'b1; BranchTarget = 10'h155;
        step();
        check("halt_pc", 32'(pc_a), 32'h020);
        check("halt_done", 32'(done_a), 32'd1);
        idle_inputs();
        BranchEn = 1'b1; Halt = 1'b1; BranchTarget = 10'h0AA;
        repeat (2) step();
        idle_inputs();

        // Wrap from the top of the address space
        start_at(10'h3FE);
        repeat (2) step();
        check("wrap_pc", 32'(pc_a), 32'h000);

        // Reset mid-run, then launch from DONE
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        start_at(10'h030);
        Halt = 1'b1;
        step();
        Halt = 1'b0;
        start_at(10'h100);
        check("restart_pc", 32'(pc_a), 32'h100);

        // 20 instructions with Start pulsed mid-run; narrow counter saturates
        repeat (10) step();
        Start = 1'b1; StartAddr = 10'h2AA;
        step();
        Start = 1'b0;
        repeat (9) step();
        check("sat_inst_b", 32'(inst_b), 32'd15);
        check("sat_inst_a", 32'(inst_a), 32'd20);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            Reset           = ($urandom_range(0, 99) == 0);
            Start           = ($urandom_range(0, 5) == 0);
            StartAddr       = PC_W'($urandom);
            BranchEn        = $urandom_range(0, 2) == 0;
            ConditionBranch = 1'($urandom);
            CondFlag        = 1'($urandom);
            BranchTarget    = PC_W'($urandom);
            Halt            = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch sequencer that sits directly upstream of the control decoder.
- Drives the instruction ROM address, and the ROM feeds the 9-bit instruction word to the decoder combinationally.
- Consumes the decoder's BranchEn / ConditionBranch / Halt outputs, the ALU condition flag and the branch-target lookup value to pick the next PC.
- Runs a start/run/done handshake with the testbench top level and keeps instruction and taken-branch counters for profiling.

Parameters:
- PC_W, 10, width of the program counter / ROM address.
- CNT_W, 16, width of the instruction and taken-branch counters.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  level request to begin execution; sampled only in IDLE or DONE.
- StartAddr  input  PC_W  first PC of the program, latched when a start is accepted.
- BranchEn  input  1  from control decoder; current instruction is a branch.
- ConditionBranch  input  1  from control decoder; branch is conditional.
- CondFlag  input  1  ALU compare flag; 1 = condition true.
- BranchTarget  input  PC_W  absolute target PC from the branch lookup table.
- Halt  input  1  from control decoder; current instruction is halt.
- ProgCtr  output  PC_W  current PC, driven to the instruction ROM address.
- Fetching  output  1  high when ProgCtr holds a live instruction (state RUN).
- Done  output  1  high while halted after a program run.
- InstCount  output  CNT_W  instructions retired in current/last run.
- BranchCount  output  CNT_W  taken branches in current/last run.

Behaviour:
- Reset (sync, active-high, takes priority over everything):
  - state=IDLE, ProgCtr=0, Fetching=0, Done=0, InstCount=0, BranchCount=0.
  - Reset asserted mid-RUN aborts the run the same edge; no counter increment for that cycle.
- States: IDLE, RUN, DONE (2-bit encoding).
- Outputs:
  - Fetching=1 only in RUN.
  - Done=1 only in DONE.
  - ProgCtr, InstCount and BranchCount are registered outputs.
- IDLE:
  - If Start=1 at the edge: next state RUN, ProgCtr<=StartAddr, both counters<=0.
  - Otherwise hold all state.
- RUN (one instruction retired per cycle; the decoder sees ROM[ProgCtr] combinationally in the same cycle). Each edge evaluates, in priority order:
  1. Halt=1: next state DONE, ProgCtr holds (points at the halt instruction), InstCount+1, BranchEn ignored.
  2. BranchEn=1 and (ConditionBranch=0 or CondFlag=1): ProgCtr<=BranchTarget, InstCount+1, BranchCount+1.
  3. Otherwise: ProgCtr<=ProgCtr+1 modulo 2^PC_W (all-ones wraps to 0, no flag), InstCount+1. A conditional branch with CondFlag=0 takes this path.
- Start is ignored in RUN; a run ends only via Halt or Reset.
- DONE:
  - Hold ProgCtr and both counters so the bench can read them.
  - If Start=1 at the edge: restart exactly as from IDLE (Done drops the same edge, counters cleared, ProgCtr<=StartAddr).
  - Start held high continuously across a halt re-launches the program one cycle after Done rises; the bench must drop Start before the halt to avoid this.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- BranchEn, ConditionBranch, CondFlag, BranchTarget and Halt are don't-care outside RUN and must not change state.
- Latency:
  - Start accepted -> first instruction address on ProgCtr: 1 cycle.
  - Branch decision -> target on ProgCtr: 1 cycle, no bubble, no delay slot.

Test Plan:
- Reset, then Start=1 with StartAddr=0x005 for one cycle: after 1 edge ProgCtr=0x005, Fetching=1; after 3 more edges with no branch/halt, ProgCtr=0x008 and InstCount=3.
- In RUN at PC 0x010, BranchEn=1, ConditionBranch=1, CondFlag=0: next ProgCtr=0x011 and BranchCount unchanged. Repeat with CondFlag=1 and BranchTarget=0x040: next ProgCtr=0x040 and BranchCount+1.
- Halt=1 and BranchEn=1 in the same cycle at PC 0x020: state DONE, ProgCtr stays 0x020, Done=1, Fetching=0, BranchCount unchanged, InstCount+1.
- Run from StartAddr=0x3FE with no branches: ProgCtr goes 0x3FE, 0x3FF, 0x000 with no stall.
- Assert Reset two cycles into a run: next edge ProgCtr=0, counters=0, Fetching=0, Done=0. Then Start from DONE with StartAddr=0x100: Done clears and ProgCtr=0x100 after 1 edge.
- With CNT_W=4, retire 20 instructions without halt: InstCount holds at 15. Start pulsed during RUN has no effect on ProgCtr.
